color_window_cache: RTL

- Parametrised per-channel pixel window buffer for the image-processing datapath. Sits between the data memory port and the colour filter/convolution unit.
- Software loads CHANNELS×WORDS words over the 32-bit store bus. The block then presents a WIN_PIX-pixel window per channel and slides it one pixel per shift request.
- Adds a load tracking FSM, valid/refill flags, shift back-pressure and write-error reporting.

---
 rtl/cwc_pkg.sv | 35 +++
 rtl/color_window_cache_if.sv | 37 +++
 rtl/cwc_channel_shreg.sv | 48 ++++
 rtl/color_window_cache.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cwc_pkg.sv
// Shared definitions for the colour window cache.
// Holds the FSM state type, the derived-geometry functions and the
// address split helpers used by the top level and the channel storage.
package cwc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } cwc_state_t;

  // Pixels per stored word.
  function automatic int calc_ppw(input int word_w, input int pix_w);
    return word_w / pix_w;
  endfunction

  // Pixels held per channel.
  function automatic int calc_depth_pix(input int words, input int word_w, input int pix_w);
    return words * calc_ppw(word_w, pix_w);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_ch(input int addr, input int words);
    return addr / words;
  endfunction

  function automatic int addr_word(input int addr, input int words);
    return addr % words;
  endfunction

endpackage

// File: rtl/color_window_cache_if.sv
// Store-bus / window-output bundle of the colour window cache.
// master: software/filter side (drives clr, we, addr, di, sh).
// slave : the cache (drives sh_ready, win_valid, win_data, need_refill,
//         fill_cnt, wr_err).
interface color_window_cache_if #(
  parameter int CHANNELS = 3,
  parameter int PIX_W    = 8,
  parameter int WORD_W   = 16,
  parameter int WORDS    = 2,
  parameter int WIN_PIX  = 3
) ();
  localparam int DEPTH_PIX = cwc_pkg::calc_depth_pix(WORDS, WORD_W, PIX_W);
  localparam int AW        = cwc_pkg::clog2_min1(CHANNELS * WORDS);
  localparam int FW        = $clog2(DEPTH_PIX + 1);

  logic                            clr;
  logic                            we;
  logic [AW-1:0]                   addr;
  logic [31:0]                     di;
  logic                            sh;
  logic                            sh_ready;
  logic                            win_valid;
  logic [CHANNELS*WIN_PIX*PIX_W-1:0] win_data;
  logic                            need_refill;
  logic [FW-1:0]                   fill_cnt;
  logic                            wr_err;

  modport master (
    output clr, we, addr, di, sh,
    input  sh_ready, win_valid, win_data, need_refill, fill_cnt, wr_err
  );

  modport slave (
    input  clr, we, addr, di, sh,
    output sh_ready, win_valid, win_data, need_refill, fill_cnt, wr_err
  );
endinterface

// File: rtl/cwc_channel_shreg.sv
// One channel's pixel storage: word write, one-pixel shift toward pixel 0
// and a combinational window tap of pixels 0..WIN_PIX-1.
// Ports: clk, rst, we (word write), wsel (word index), wdata (word),
//        sh (shift), win (window, pixel 0 in MSBs).
module cwc_channel_shreg import cwc_pkg::*; #(
  parameter int PIX_W   = 8,
  parameter int WORD_W  = 16,
  parameter int WORDS   = 2,
  parameter int WIN_PIX = 3,
  parameter int WIDX_W  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [WIDX_W-1:0]        wsel,
  input  logic [WORD_W-1:0]        wdata,
  input  logic                     sh,
  output logic [WIN_PIX*PIX_W-1:0] win
);
  localparam int PPW   = calc_ppw(WORD_W, PIX_W);
  localparam int DEPTH = calc_depth_pix(WORDS, WORD_W, PIX_W);

  logic [PIX_W-1:0] pix [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pix[i] <= '0;
    end else if (sh) begin
      for (int i = 0; i < DEPTH - 1; i++) pix[i] <= pix[i+1];
      pix[DEPTH-1] <= '0;
    end else if (we) begin
      // Oldest pixel of a word sits in its MSBs.
      for (int w = 0; w < WORDS; w++) begin
        if (wsel == WIDX_W'(w)) begin
          for (int p = 0; p < PPW; p++)
            pix[w*PPW + p] <= wdata[WORD_W-1-p*PIX_W -: PIX_W];
        end
      end
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < WIN_PIX; i++)
      win[(WIN_PIX-i)*PIX_W-1 -: PIX_W] = pix[i];
  end

endmodule

// File: rtl/color_window_cache.sv
// Per-channel pixel window buffer between the store bus and the colour
// filter. Software loads CHANNELS*WORDS words; once all are present the
// block presents a WIN_PIX-pixel window per channel and slides it one
// pixel per accepted shift, asking for a refill when it runs short.
// Ports: clk, rst (sync, active-high), bus (slave side of
//        color_window_cache_if: clr/we/addr/di/sh in; sh_ready,
//        win_valid, win_data, need_refill, fill_cnt, wr_err out).
module color_window_cache import cwc_pkg::*; #(
  parameter int CHANNELS = 3,
  parameter int PIX_W    = 8,
  parameter int WORD_W   = 16,
  parameter int WORDS    = 2,
  parameter int WIN_PIX  = 3
) (
  input  logic               clk,
  input  logic               rst,
  color_window_cache_if.slave bus
);
  localparam int N      = CHANNELS * WORDS;
  localparam int DEPTH  = calc_depth_pix(WORDS, WORD_W, PIX_W);
  localparam int AW     = clog2_min1(N);
  localparam int FW     = $clog2(DEPTH + 1);
  localparam int WB     = WIN_PIX * PIX_W;
  localparam int WIDX_W = clog2_min1(WORDS);
  localparam int CHW    = clog2_min1(CHANNELS);

  cwc_state_t        state;
  logic [N-1:0]      mask;
  logic [FW-1:0]     fill;
  logic              need_refill;
  logic              wr_err;

  logic              run;
  logic              win_ok;
  logic              addr_ok;
  logic              sh_acc;
  logic              wr_acc;
  logic              wr_rej;
  logic [CHW-1:0]    ch_sel;
  logic [WIDX_W-1:0] w_sel;
  logic [N-1:0]      mask_next;
  logic [FW-1:0]     fill_dec;

  always_comb begin
    run       = (state == RUN);
    win_ok    = (fill >= FW'(WIN_PIX));
    addr_ok   = (int'(bus.addr) < N);
    ch_sel    = CHW'(addr_ch(int'(bus.addr), WORDS));
    w_sel     = WIDX_W'(addr_word(int'(bus.addr), WORDS));
    // clr outranks both sh and we, so it also suppresses the error pulse.
    sh_acc    = run && bus.sh && win_ok && !bus.clr;
    wr_acc    = bus.we && addr_ok && !run && !bus.clr;
    wr_rej    = bus.we && !bus.clr && (run || !addr_ok);
    mask_next = mask | (N'(1) << bus.addr);
    fill_dec  = fill - FW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      mask        <= '0;
      fill        <= '0;
      need_refill <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      wr_err <= wr_rej;
      if (bus.clr) begin
        state       <= EMPTY;
        mask        <= '0;
        fill        <= '0;
        need_refill <= 1'b0;
      end else begin
        case (state)
          EMPTY, LOAD: begin
            if (wr_acc) begin
              if (&mask_next) begin
                state       <= RUN;
                fill        <= FW'(DEPTH);
                mask        <= '0;
                need_refill <= 1'b0;
              end else begin
                state <= LOAD;
                mask  <= mask_next;
              end
            end
          end
          RUN: begin
            if (sh_acc) begin
              fill <= fill_dec;
              if (fill_dec < FW'(WIN_PIX)) begin
                state       <= LOAD;
                need_refill <= 1'b1;
              end
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WB-1:0] win;
    cwc_channel_shreg #(
      .PIX_W  (PIX_W),
      .WORD_W (WORD_W),
      .WORDS  (WORDS),
      .WIN_PIX(WIN_PIX),
      .WIDX_W (WIDX_W)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .we   (wr_acc && (ch_sel == CHW'(c))),
      .wsel (w_sel),
      .wdata(bus.di[WORD_W-1:0]),
      .sh   (sh_acc),
      .win  (win)
    );
    // Channel 0 occupies the top of the packed window bus.
    assign bus.win_data[(CHANNELS-c)*WB-1 -: WB] = win;
  end

  if (WORD_W < 32) begin : g_di_unused
    logic unused_di;
    assign unused_di = ^bus.di[31:WORD_W];
  end

  assign bus.sh_ready    = run && win_ok;
  assign bus.win_valid   = run && win_ok;
  assign bus.need_refill = need_refill;
  assign bus.fill_cnt    = fill;
  assign bus.wr_err      = wr_err;

endmodule
